// File: rtl/hpdcache_rsp_router.sv
// -----------------------------------------------------------------------------
// hpdcache_rsp_router
//
// Return-path companion to the fixed-priority request arbiter. A small circular
// FIFO records, in grant order, the index of the requester that won each
// accepted request. In-order responses from the shared downstream resource are
// steered back to the requester at the FIFO head.
//
// Ports
//   clk_i          clock, all state on rising edge
//   rst_i          asynchronous reset, active-high
//   req_gnt_i      [N]   one-hot grant vector from the request arbiter
//   req_fire_i           granted request accepted downstream this cycle
//   track_ready_o        tracker can record a new request
//   rsp_valid_i          downstream response valid
//   rsp_ready_o          downstream response accepted
//   rsp_data_i     [W]   downstream response payload
//   rsp_valid_o    [N]   per-requester response valid (at most one set)
//   rsp_ready_i    [N]   per-requester response ready
//   rsp_data_o     [W]   response payload, shared by all requesters
//   outstanding_o  [CW]  number of recorded, unanswered requests
//   err_o                sticky protocol-error flag
// -----------------------------------------------------------------------------
module hpdcache_rsp_router #(
   parameter  int unsigned N     = 4,
   parameter  int unsigned DEPTH = 4,
   parameter  int unsigned W     = 64,
   localparam int unsigned IDW   = (N > 1) ? $clog2(N) : 1,
   localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic [N-1:0]  req_gnt_i,
   input  logic          req_fire_i,
   output logic          track_ready_o,
   input  logic          rsp_valid_i,
   output logic          rsp_ready_o,
   input  logic [W-1:0]  rsp_data_i,
   output logic [N-1:0]  rsp_valid_o,
   input  logic [N-1:0]  rsp_ready_i,
   output logic [W-1:0]  rsp_data_o,
   output logic [CW-1:0] outstanding_o,
   output logic          err_o
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   // Pointers wrap explicitly so DEPTH need not be a power of two.
   function automatic logic [PW-1:0] f_ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   logic [IDW-1:0] r_fifo [DEPTH];
   logic [PW-1:0]  r_wr_ptr;
   logic [PW-1:0]  r_rd_ptr;
   logic [CW-1:0]  r_count;
   logic           r_err;

   logic           w_full;
   logic           w_empty;
   logic           w_gnt_onehot;
   logic           w_push;
   logic           w_pop;
   logic           w_err_evt;
   logic [IDW-1:0] w_gnt_idx;
   logic [IDW-1:0] w_head;
   logic           w_rsp_ready;

   assign w_full       = (r_count == CW'(DEPTH));
   assign w_empty      = (r_count == '0);
   assign w_gnt_onehot = $onehot(req_gnt_i);

   // Ready comes from registered count only; a same-cycle pop does not free a slot.
   assign track_ready_o = ~w_full;
   assign w_push        = req_fire_i & track_ready_o & w_gnt_onehot;
   assign w_head        = r_fifo[r_rd_ptr];

   // Binary encode of the grant; only meaningful when the grant is one-hot.
   always_comb begin
      // NOTE: every combinational output gets a default first so no latch is inferred.
      w_gnt_idx = '0;
      for (int k = 0; k < N; k++) begin
         if (req_gnt_i[k]) w_gnt_idx = IDW'(k);
      end
   end

   // Steer valid to the head requester and take its ready back downstream.
   always_comb begin
      rsp_valid_o = '0;
      w_rsp_ready = 1'b0;
      for (int k = 0; k < N; k++) begin
         if (!w_empty && (w_head == IDW'(k))) begin
            rsp_valid_o[k] = rsp_valid_i;
            w_rsp_ready    = rsp_ready_i[k];
         end
      end
   end

   assign rsp_ready_o   = w_rsp_ready;
   assign rsp_data_o    = rsp_data_i;
   assign w_pop         = rsp_valid_i & w_rsp_ready;
   assign outstanding_o = r_count;
   assign err_o         = r_err;

   // Lost request, malformed grant, or a response with nothing recorded.
   assign w_err_evt = (req_fire_i & w_full)
                    | (req_fire_i & ~w_gnt_onehot)
                    | (rsp_valid_i & w_empty & ~w_push);

   // NOTE: FIFO storage has no reset; entries are only read below r_count, so
   // stale contents are never observed and the array maps to plain flops/RAM.
   always_ff @(posedge clk_i) begin
      if (w_push) r_fifo[r_wr_ptr] <= w_gnt_idx;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_err    <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= f_ptr_inc(r_wr_ptr);
         if (w_pop)  r_rd_ptr <= f_ptr_inc(r_rd_ptr);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         r_err <= r_err | w_err_evt;
      end
   end

   a_valid_onehot0 : assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(rsp_valid_o));

endmodule

// File: tb/tb_hpdcache_rsp_router.sv
module tb_hpdcache_rsp_router;

   localparam int N     = 4;
   localparam int DEPTH = 3;
   localparam int W     = 64;
   localparam int CW    = $clog2(DEPTH + 1);

   typedef struct {
      int          id;
      logic [W-1:0] data;
   } exp_t;

   logic          clk_i;
   logic          rst_i;
   logic [N-1:0]  req_gnt_i;
   logic          req_fire_i;
   logic          track_ready_o;
   logic          rsp_valid_i;
   logic          rsp_ready_o;
   logic [W-1:0]  rsp_data_i;
   logic [N-1:0]  rsp_valid_o;
   logic [N-1:0]  rsp_ready_i;
   logic [W-1:0]  rsp_data_o;
   logic [CW-1:0] outstanding_o;
   logic          err_o;

   exp_t          exp_q[$];
   int            checks = 0;
   int            errors = 0;
   logic [N-1:0]  s_rsp_valid;
   logic          s_rsp_ready;

   hpdcache_rsp_router #(.N(N), .DEPTH(DEPTH), .W(W)) dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .req_gnt_i     (req_gnt_i),
      .req_fire_i    (req_fire_i),
      .track_ready_o (track_ready_o),
      .rsp_valid_i   (rsp_valid_i),
      .rsp_ready_o   (rsp_ready_o),
      .rsp_data_i    (rsp_data_i),
      .rsp_valid_o   (rsp_valid_o),
      .rsp_ready_i   (rsp_ready_i),
      .rsp_data_o    (rsp_data_o),
      .outstanding_o (outstanding_o),
      .err_o         (err_o)
   );

   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every accepted downstream response must go to the next recorded requester.
   always @(negedge clk_i) begin : monitor
      exp_t         e;
      logic [N-1:0] oh;
      if (!rst_i && rsp_valid_i === 1'b1 && rsp_ready_o === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rsp: got rsp_valid_o=%0h expected no handshake", rsp_valid_o);
         end else begin
            e  = exp_q.pop_front();
            oh = '0;
            oh[e.id] = 1'b1;
            check("rsp_route", W'(rsp_valid_o), W'(oh));
            check("rsp_data", rsp_data_o, e.data);
         end
      end
   end

   // One clock: drive, sample combinational outputs mid-cycle, pass the edge.
   task automatic cyc(input logic fire, input logic [N-1:0] gnt, input logic rv,
                      input logic [W-1:0] d, input logic [N-1:0] rr);
      req_fire_i  = fire;
      req_gnt_i   = gnt;
      rsp_valid_i = rv;
      rsp_data_i  = d;
      rsp_ready_i = rr;
      @(negedge clk_i);
      #1;
      s_rsp_valid = rsp_valid_o;
      s_rsp_ready = rsp_ready_o;
      @(posedge clk_i);
      #1;
      req_fire_i  = 1'b0;
      req_gnt_i   = '0;
      rsp_valid_i = 1'b0;
      rsp_ready_i = '0;
   endtask

   task automatic push(input logic [N-1:0] gnt, input int id, input logic [W-1:0] d);
      exp_q.push_back('{id: id, data: d});
      cyc(1'b1, gnt, 1'b0, '0, '0);
   endtask

   task automatic rsp(input logic [W-1:0] d);
      cyc(1'b0, '0, 1'b1, d, '1);
   endtask

   // Asynchronous pulse in the middle of a cycle; outputs must clear immediately.
   task automatic do_reset();
      #2 rst_i = 1'b1;
      exp_q.delete();
      #1;
      check("rst_track_ready", W'(track_ready_o), 1);
      check("rst_outstanding", W'(outstanding_o), 0);
      check("rst_err", W'(err_o), 0);
      check("rst_rsp_valid", W'(rsp_valid_o), 0);
      check("rst_rsp_ready", W'(rsp_ready_o), 0);
      #2 rst_i = 1'b0;
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      rst_i       = 1'b0;
      req_gnt_i   = '0;
      req_fire_i  = 1'b0;
      rsp_valid_i = 1'b0;
      rsp_data_i  = '0;
      rsp_ready_i = '0;
      @(posedge clk_i);
      #1;
      do_reset();

      // In-order routing; third push fills the DEPTH=3 tracker.
      push(4'b0100, 2, 64'hA);
      push(4'b0001, 0, 64'hB);
      push(4'b1000, 3, 64'hC);
      check("order_outstanding_full", W'(outstanding_o), 3);
      check("order_track_ready_full", W'(track_ready_o), 0);
      rsp(64'hA);
      check("order_outstanding_2", W'(outstanding_o), 2);
      rsp(64'hB);
      rsp(64'hC);
      check("order_outstanding_0", W'(outstanding_o), 0);
      check("order_track_ready", W'(track_ready_o), 1);
      check("order_err", W'(err_o), 0);

      // Response arriving with the push into an empty tracker is held off.
      exp_q.push_back('{id: 1, data: 64'h5A});
      cyc(1'b1, 4'b0010, 1'b1, 64'h5A, '1);
      check("nobypass_rsp_ready", W'(s_rsp_ready), 0);
      check("nobypass_rsp_valid", W'(s_rsp_valid), 0);
      check("nobypass_err", W'(err_o), 0);
      check("nobypass_outstanding", W'(outstanding_o), 1);
      rsp(64'h5A);
      check("nobypass_drained", W'(outstanding_o), 0);

      // Backpressure on head requester 2.
      push(4'b0100, 2, 64'hD);
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, '0, 1'b1, 64'hD, 4'b1011);
         check("bp_rsp_ready", W'(s_rsp_ready), 0);
         check("bp_rsp_valid", W'(s_rsp_valid), W'(4'b0100));
         check("bp_outstanding", W'(outstanding_o), 1);
      end
      cyc(1'b0, '0, 1'b1, 64'hD, 4'b1111);
      check("bp_released", W'(outstanding_o), 0);

      // Full, then sustained push+pop so both pointers wrap several times.
      push(4'b0001, 0, 64'h30);
      push(4'b0010, 1, 64'h31);
      push(4'b0100, 2, 64'h32);
      check("wrap_full_ready", W'(track_ready_o), 0);
      rsp(64'h30);
      check("wrap_ready_after_pop", W'(track_ready_o), 1);
      for (int i = 0; i < 10; i++) begin
         logic [N-1:0] g;
         logic [W-1:0] hd;
         g  = N'(1) << (i % 4);
         hd = (i < 2) ? W'(64'h31 + i) : W'(64'h100 + i - 2);
         exp_q.push_back('{id: i % 4, data: W'(64'h100 + i)});
         cyc(1'b1, g, 1'b1, hd, '1);
         check("wrap_outstanding", W'(outstanding_o), 2);
      end
      rsp(64'h108);
      rsp(64'h109);
      check("wrap_drained", W'(outstanding_o), 0);
      check("wrap_err", W'(err_o), 0);

      // Push and pop in the same cycle at count=1.
      push(4'b0001, 0, 64'h40);
      exp_q.push_back('{id: 1, data: 64'h41});
      cyc(1'b1, 4'b0010, 1'b1, 64'h40, '1);
      check("sim_outstanding", W'(outstanding_o), 1);
      check("sim_err", W'(err_o), 0);
      rsp(64'h41);
      check("sim_drained", W'(outstanding_o), 0);

      // Error: fire while full; entries then discarded by reset.
      push(4'b1000, 3, 64'h50);
      push(4'b1000, 3, 64'h51);
      push(4'b1000, 3, 64'h52);
      cyc(1'b1, 4'b0001, 1'b0, '0, '0);
      check("err_full_flag", W'(err_o), 1);
      check("err_full_outstanding", W'(outstanding_o), 3);
      do_reset();

      // Error: response while empty.
      cyc(1'b0, '0, 1'b1, 64'h77, '1);
      check("err_empty_rsp_ready", W'(s_rsp_ready), 0);
      check("err_empty_rsp_valid", W'(s_rsp_valid), 0);
      check("err_empty_flag", W'(err_o), 1);
      cyc(1'b0, '0, 1'b0, '0, '0);
      check("err_sticky", W'(err_o), 1);
      do_reset();

      // Error: non-one-hot grant is not recorded.
      cyc(1'b1, 4'b0110, 1'b0, '0, '0);
      check("err_gnt_flag", W'(err_o), 1);
      check("err_gnt_outstanding", W'(outstanding_o), 0);
      do_reset();

      check("exp_queue_empty", W'(exp_q.size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
